// File: rtl/pair_sched.sv
// Double-buffered configuration scheduler: cfg words load a shadow bank, a commit swaps it
// into the active bank after draining the packet pipe, and packets are issued with active ctl.
module pair_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i__cfg_valid,
    input  logic [4:0]   i__cfg_addr,
    input  logic [31:0]  i__cfg_data,
    output logic         o__cfg_ready,
    input  logic         i__cfg_commit,
    output logic         o__cfg_busy,
    output logic         o__cfg_err,
    input  logic         i__err_clr,
    input  logic         i__pkt_valid,
    input  logic [31:0]  i__pkt_1,
    input  logic [31:0]  i__pkt_2,
    output logic         o__pkt_ready,
    output logic [31:0]  o__pkt_1,
    output logic [31:0]  o__pkt_2,
    output logic [607:0] o__cons,
    output logic [54:0]  o__ctl,
    output logic [15:0]  o__pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t         state_r;
    logic [607:0]   shadow_cons_r;
    logic [607:0]   active_cons_r;
    logic [54:0]    shadow_ctl_r;
    logic [54:0]    active_ctl_r;
    logic [20:0]    mask_r;
    logic           err_r;
    logic [31:0]    pkt_1_r;
    logic [31:0]    pkt_2_r;
    logic [54:0]    ctl_r;
    logic [15:0]    pkt_cnt_r;

    logic           idle_s;
    logic           cfg_wr_s;
    logic           addr_ok_s;
    logic [20:0]    wr_bit_s;
    logic [20:0]    mask_next_s;
    logic           commit_ok_s;
    logic           commit_bad_s;
    logic           addr_err_s;
    logic           pkt_acc_s;

    // Decode of accept/commit conditions; a same-cycle write counts toward the commit mask.
    always_comb begin
        idle_s       = (state_r == IDLE);
        cfg_wr_s     = i__cfg_valid & idle_s;
        addr_ok_s    = (i__cfg_addr <= 5'd20);
        wr_bit_s     = 21'd0;
        if (cfg_wr_s && addr_ok_s) begin
            wr_bit_s = 21'd1 << i__cfg_addr;
        end else begin
            wr_bit_s = 21'd0;
        end
        mask_next_s  = mask_r | wr_bit_s;
        commit_ok_s  = idle_s & i__cfg_commit & (&mask_next_s);
        commit_bad_s = idle_s & i__cfg_commit & ~(&mask_next_s);
        addr_err_s   = cfg_wr_s & ~addr_ok_s;
        pkt_acc_s    = i__pkt_valid & idle_s;
    end

    // Shadow/active banks and the written-word mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_cons_r <= 608'd0;
            shadow_ctl_r  <= 55'd0;
            active_cons_r <= 608'd0;
            active_ctl_r  <= 55'd0;
            mask_r        <= 21'd0;
        end else begin
            if (cfg_wr_s && addr_ok_s) begin
                if (i__cfg_addr < 5'd19) begin
                    shadow_cons_r[{i__cfg_addr, 5'd0} +: 32] <= i__cfg_data;
                end else if (i__cfg_addr == 5'd19) begin
                    shadow_ctl_r[31:0] <= i__cfg_data;
                end else begin
                    shadow_ctl_r[54:32] <= i__cfg_data[22:0];
                end
            end
            if (state_r == COMMIT) begin
                active_cons_r <= shadow_cons_r;
                active_ctl_r  <= shadow_ctl_r;
                mask_r        <= 21'd0;
            end else begin
                mask_r <= mask_next_s;
            end
        end
    end

    // Commit sequencer plus packet issue path, error flag and packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            err_r     <= 1'b0;
            pkt_1_r   <= 32'd0;
            pkt_2_r   <= 32'd0;
            ctl_r     <= 55'd0;
            pkt_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE:    state_r <= commit_ok_s ? PEND : IDLE;
                PEND:    state_r <= DRAIN;
                DRAIN:   state_r <= COMMIT;
                COMMIT:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
            err_r <= (err_r & ~i__err_clr) | commit_bad_s | addr_err_s;
            // Bubbles issue zeros so the downstream atom computes state + 0 - 0.
            if (pkt_acc_s) begin
                pkt_1_r   <= i__pkt_1;
                pkt_2_r   <= i__pkt_2;
                ctl_r     <= active_ctl_r;
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end else begin
                pkt_1_r   <= 32'd0;
                pkt_2_r   <= 32'd0;
                ctl_r     <= 55'd0;
            end
        end
    end

    assign o__cfg_ready = (state_r == IDLE);
    assign o__pkt_ready = (state_r == IDLE);
    assign o__cfg_busy  = (state_r != IDLE);
    assign o__cfg_err   = err_r;
    assign o__pkt_1     = pkt_1_r;
    assign o__pkt_2     = pkt_2_r;
    assign o__ctl       = ctl_r;
    assign o__cons      = active_cons_r;
    assign o__pkt_cnt   = pkt_cnt_r;

endmodule

// File: tb/tb_pair_sched.sv
// Bench for pair_sched: transaction-level model compared every cycle, plus literal spot checks.
module tb_pair_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i__cfg_valid = 1'b0;
    logic [4:0]   i__cfg_addr = 5'd0;
    logic [31:0]  i__cfg_data = 32'd0;
    logic         o__cfg_ready;
    logic         i__cfg_commit = 1'b0;
    logic         o__cfg_busy;
    logic         o__cfg_err;
    logic         i__err_clr = 1'b0;
    logic         i__pkt_valid = 1'b0;
    logic [31:0]  i__pkt_1 = 32'd0;
    logic [31:0]  i__pkt_2 = 32'd0;
    logic         o__pkt_ready;
    logic [31:0]  o__pkt_1;
    logic [31:0]  o__pkt_2;
    logic [607:0] o__cons;
    logic [54:0]  o__ctl;
    logic [15:0]  o__pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pair_sched dut (
        .clk(clk), .rst_n(rst_n),
        .i__cfg_valid(i__cfg_valid), .i__cfg_addr(i__cfg_addr), .i__cfg_data(i__cfg_data),
        .o__cfg_ready(o__cfg_ready), .i__cfg_commit(i__cfg_commit), .o__cfg_busy(o__cfg_busy),
        .o__cfg_err(o__cfg_err), .i__err_clr(i__err_clr),
        .i__pkt_valid(i__pkt_valid), .i__pkt_1(i__pkt_1), .i__pkt_2(i__pkt_2),
        .o__pkt_ready(o__pkt_ready), .o__pkt_1(o__pkt_1), .o__pkt_2(o__pkt_2),
        .o__cons(o__cons), .o__ctl(o__ctl), .o__pkt_cnt(o__pkt_cnt)
    );

    initial forever #5 clk = ~clk;

    // Model: banks as word arrays, a commit is a 3-cycle busy countdown ending in a copy.
    logic [31:0] m_shadow [0:20];
    logic [31:0] m_active [0:20];
    bit          m_mask   [0:20];
    int          busy_left;
    logic        m_err;
    logic [15:0] m_cnt;
    logic [31:0] m_p1, m_p2;
    logic [54:0] m_ctl;

    function automatic logic [54:0] act_ctl();
        return {m_active[20][22:0], m_active[19]};
    endfunction

    function automatic logic [607:0] exp_cons();
        logic [607:0] v = 608'd0;
        for (int k = 0; k < 19; k++) v[k*32 +: 32] = m_active[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 21; a++) begin
            m_shadow[a] = 32'd0; m_active[a] = 32'd0; m_mask[a] = 1'b0;
        end
        busy_left = 0; m_err = 1'b0; m_cnt = 16'd0;
        m_p1 = 32'd0; m_p2 = 32'd0; m_ctl = 55'd0;
    endtask

    task automatic model_step();
        bit idle = (busy_left == 0);
        bit nerr = 1'b0;
        bit all_set;
        if (idle && i__cfg_valid) begin
            if (i__cfg_addr <= 5'd20) begin
                m_shadow[i__cfg_addr] = i__cfg_data;
                m_mask[i__cfg_addr] = 1'b1;
            end else nerr = 1'b1;
        end
        if (idle && i__pkt_valid) begin
            m_p1 = i__pkt_1; m_p2 = i__pkt_2; m_ctl = act_ctl(); m_cnt = m_cnt + 16'd1;
        end else begin
            m_p1 = 32'd0; m_p2 = 32'd0; m_ctl = 55'd0;
        end
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                for (int a = 0; a < 21; a++) begin
                    m_active[a] = m_shadow[a]; m_mask[a] = 1'b0;
                end
            end
        end else if (i__cfg_commit) begin
            all_set = 1'b1;
            for (int a = 0; a < 21; a++) if (!m_mask[a]) all_set = 1'b0;
            if (all_set) busy_left = 3;
            else nerr = 1'b1;
        end
        m_err = (m_err && !i__err_clr) || nerr;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string nm, input logic [607:0] act, input logic [607:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("cfg_ready", o__cfg_ready, busy_left == 0);
        chk("pkt_ready", o__pkt_ready, busy_left == 0);
        chk("cfg_busy",  o__cfg_busy,  busy_left != 0);
        chk("cfg_err",   o__cfg_err,   m_err);
        chk("pkt_1",     o__pkt_1,     m_p1);
        chk("pkt_2",     o__pkt_2,     m_p2);
        chk("ctl",       o__ctl,       m_ctl);
        chk("cons",      o__cons,      exp_cons());
        chk("pkt_cnt",   o__pkt_cnt,   m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        i__cfg_valid = 1'b1; i__cfg_addr = a; i__cfg_data = d;
        step();
        i__cfg_valid = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        chk("rst_cons", o__cons, 608'd0);
        chk("rst_ready", o__cfg_ready, 1'b1);
        chk("rst_cnt", o__pkt_cnt, 16'd0);
        rst_n = 1'b1;
        step();

        // Packet (5,7) under an all-zero active bank, then a bubble.
        i__pkt_valid = 1'b1; i__pkt_1 = 32'd5; i__pkt_2 = 32'd7;
        step();
        i__pkt_valid = 1'b0;
        chk("pkt57_p1", o__pkt_1, 32'd5);
        chk("pkt57_p2", o__pkt_2, 32'd7);
        chk("pkt57_ctl", o__ctl, 55'd0);
        chk("pkt57_cnt", o__pkt_cnt, 16'd1);
        step();
        chk("bubble_p1", o__pkt_1, 32'd0);
        chk("bubble_p2", o__pkt_2, 32'd0);

        // Incomplete mask: commit refused with error.
        for (int a = 0; a < 20; a++) cfg_write(5'(a), 32'hA5A50000 + 32'(a));
        i__cfg_commit = 1'b1;
        step();
        i__cfg_commit = 1'b0;
        chk("partial_err", o__cfg_err, 1'b1);
        chk("partial_busy", o__cfg_busy, 1'b0);
        chk("partial_cons", o__cons, 608'd0);

        // Clear and new error in the same cycle keep the flag.
        i__err_clr = 1'b1;
        cfg_write(5'd25, 32'hDEADBEEF);
        chk("clr_vs_err", o__cfg_err, 1'b1);
        step();
        i__err_clr = 1'b0;
        chk("err_cleared", o__cfg_err, 1'b0);

        // Last word with commit in the same cycle; a packet held valid across the commit.
        i__cfg_valid = 1'b1; i__cfg_addr = 5'd20; i__cfg_data = 32'hA5A50014;
        i__cfg_commit = 1'b1;
        i__pkt_valid = 1'b1; i__pkt_1 = 32'd11; i__pkt_2 = 32'd22;
        step();
        i__cfg_valid = 1'b0;
        chk("pend_busy", o__cfg_busy, 1'b1);
        chk("pend_pkt_ready", o__pkt_ready, 1'b0);
        chk("commit_cycle_pkt", o__pkt_1, 32'd11);
        i__cfg_commit = 1'b1;
        step();
        i__cfg_commit = 1'b0;
        chk("drain_busy", o__cfg_busy, 1'b1);
        chk("ignored_commit_err", o__cfg_err, 1'b0);
        step();
        chk("commit_busy", o__cfg_busy, 1'b1);
        chk("commit_old_cons", o__cons[31:0], 32'd0);
        step();
        chk("idle_busy", o__cfg_busy, 1'b0);
        chk("new_word0", o__cons[31:0], 32'hA5A50000);
        chk("new_word18", o__cons[607:576], 32'hA5A50012);
        chk("held_bubble", o__pkt_1, 32'd0);
        step();
        i__pkt_valid = 1'b0;
        chk("held_pkt", o__pkt_1, 32'd11);
        chk("held_ctl", o__ctl, 55'h250014A5A50013);

        // Mask was cleared by the commit.
        i__cfg_commit = 1'b1;
        step();
        i__cfg_commit = 1'b0;
        chk("mask_cleared", o__cfg_err, 1'b1);
        i__err_clr = 1'b1;
        step();
        i__err_clr = 1'b0;

        // Reset asserted mid-cycle during DRAIN.
        for (int a = 0; a < 20; a++) cfg_write(5'(a), 32'h5A5A0000 + 32'(a));
        i__cfg_commit = 1'b1;
        cfg_write(5'd20, 32'h5A5A0014);
        i__cfg_commit = 1'b0;
        step();
        chk("drain_reached", o__cfg_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", o__cfg_busy, 1'b0);
        chk("async_ready", o__cfg_ready, 1'b1);
        chk("async_cons", o__cons, 608'd0);
        chk("async_cnt", o__pkt_cnt, 16'd0);
        chk("async_ctl", o__ctl, 55'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_ready", o__cfg_ready, 1'b1);
        chk("post_rst_cons", o__cons, 608'd0);

        // Counter wrap.
        i__pkt_valid = 1'b1; i__pkt_1 = 32'd1; i__pkt_2 = 32'd2;
        repeat (65535) @(posedge clk);
        #1;
        chk("cnt_ffff", o__pkt_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("cnt_wrap", o__pkt_cnt, 16'h0000);
        i__pkt_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
